// File: rtl/bcd_tens_stage.sv
// Tens-digit stage for a BCD decade counter: detects the units 9->0 wrap, counts tens
// modulo TENS_MAX+1, emits wrap/carry pulses and flags illegal units sequences.
module bcd_tens_stage #(
  parameter int unsigned TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] units,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] tens,
  output logic       wrap,
  output logic       carry,
  output logic       err
);

  localparam logic [3:0] TensMax = 4'(TENS_MAX);

  logic [3:0] prev_q, prev_d;
  logic       pv_q, pv_d;
  logic [3:0] tens_q, tens_d;
  logic       wrap_q, wrap_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;

  logic       is_wrap;
  logic       step_ok;
  logic       bad;

  always_comb begin
    is_wrap = pv_q && (prev_q == 4'd9) && (units == 4'd0);
    step_ok = (units == prev_q) || ((prev_q <= 4'd8) && (units == prev_q + 4'd1)) || is_wrap;
    // The priming edge (pv_q == 0) performs no checks at all.
    bad     = pv_q && (!step_ok || (units > 4'd9));
  end

  always_comb begin
    prev_d  = units;
    pv_d    = 1'b1;
    tens_d  = tens_q;
    wrap_d  = 1'b0;
    carry_d = 1'b0;
    err_d   = err_q | bad;

    if (clr) begin
      prev_d = prev_q;
      pv_d   = 1'b0;
      tens_d = 4'd0;
      err_d  = 1'b0;
    end else if (is_wrap) begin
      wrap_d = 1'b1;
      if (en) begin
        if (tens_q >= TensMax) begin
          tens_d  = 4'd0;
          carry_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prev_q  <= 4'd0;
      pv_q    <= 1'b0;
      tens_q  <= 4'd0;
      wrap_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      tens_q  <= tens_d;
      wrap_q  <= wrap_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign tens  = tens_q;
  assign wrap  = wrap_q;
  assign carry = carry_q;
  assign err   = err_q;

endmodule
